// File: rtl/pio_cmd_master_if.sv
// Bundle of request, PIO bus and response signals for pio_cmd_master.
// The master modport is the design side; the slave modport is the requester/bus side.
interface pio_cmd_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // Request side
  logic              req_vld;
  logic              req_rdy;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  // PIO bus side
  logic              cmd_vld;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_w;
  logic              rw;
  logic              drive_en;
  logic [DATA_W-1:0] data_r;
  logic              rd_vld;
  // Response and status
  logic              rsp_vld;
  logic              rsp_rw;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              stray_rd;
  logic              idle;

  modport master (
    input  req_vld, req_rw, req_addr, req_data, data_r, rd_vld,
    output req_rdy, cmd_vld, addr, data_w, rw, drive_en,
    output rsp_vld, rsp_rw, rsp_addr, rsp_data, rsp_err, stray_rd, idle
  );

  modport slave (
    output req_vld, req_rw, req_addr, req_data, data_r, rd_vld,
    input  req_rdy, cmd_vld, addr, data_w, rw, drive_en,
    input  rsp_vld, rsp_rw, rsp_addr, rsp_data, rsp_err, stray_rd, idle
  );
endinterface

// File: rtl/pio_cmd_master.sv
// Queued PIO bus master: buffers read/write requests in a small FIFO, issues
// them one at a time as single-cycle commands, waits for read data with a
// timeout, and returns one in-order response per request.
module pio_cmd_master #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  pio_cmd_master_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(DEPTH);
  // Last WAIT_RD cycle: counter starts at 0, so TIMEOUT cycles end at TIMEOUT-1
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  req_t              fifo_mem [DEPTH];
  req_t              head;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic [CNT_W-1:0]  tmo_cnt_reg;
  state_t            state_reg;
  logic              cur_rw_reg;
  logic [ADDR_W-1:0] cur_addr_reg;
  logic              push;
  logic              pop;
  logic              rd_pending;

  assign bus.req_rdy  = !rst && (count_reg < DEPTH_C);
  assign push         = bus.req_vld && bus.req_rdy;
  assign pop          = (state_reg == IDLE) && (count_reg != '0);
  assign head         = fifo_mem[rd_ptr_reg];
  assign rd_pending   = ((state_reg == ISSUE) && !cur_rw_reg) || (state_reg == WAIT_RD);
  assign bus.drive_en = bus.cmd_vld;
  assign bus.idle     = (count_reg == '0) && (state_reg == IDLE);

  // Request storage; left unreset so it can map onto distributed RAM
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {bus.req_rw, bus.req_addr, bus.req_data};
    end
  end

  // FIFO bookkeeping, command sequencing and registered bus/response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      tmo_cnt_reg  <= '0;
      cur_rw_reg   <= 1'b0;
      cur_addr_reg <= '0;
      bus.cmd_vld  <= 1'b0;
      bus.addr     <= '0;
      bus.data_w   <= '0;
      bus.rw       <= 1'b0;
      bus.rsp_vld  <= 1'b0;
      bus.rsp_rw   <= 1'b0;
      bus.rsp_addr <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
      bus.stray_rd <= 1'b0;
    end else begin
      // Response is a single-cycle pulse; fields read as zero between pulses
      bus.rsp_vld  <= 1'b0;
      bus.rsp_rw   <= 1'b0;
      bus.rsp_addr <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;

      // Read data with nothing outstanding is only flagged, never consumed
      if (bus.rd_vld && !rd_pending) bus.stray_rd <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (pop) begin
            bus.cmd_vld  <= 1'b1;
            bus.addr     <= head.addr;
            bus.data_w   <= head.data;
            bus.rw       <= head.rw;
            cur_rw_reg   <= head.rw;
            cur_addr_reg <= head.addr;
            state_reg    <= ISSUE;
          end
        end
        ISSUE: begin
          // Command is on the bus for this cycle only
          bus.cmd_vld <= 1'b0;
          bus.addr    <= '0;
          bus.data_w  <= '0;
          bus.rw      <= 1'b0;
          if (cur_rw_reg) begin
            bus.rsp_vld  <= 1'b1;
            bus.rsp_rw   <= 1'b1;
            bus.rsp_addr <= cur_addr_reg;
            state_reg    <= IDLE;
          end else if (bus.rd_vld) begin
            bus.rsp_vld  <= 1'b1;
            bus.rsp_addr <= cur_addr_reg;
            bus.rsp_data <= bus.data_r;
            state_reg    <= IDLE;
          end else begin
            tmo_cnt_reg <= '0;
            state_reg   <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // Data arriving on the final allowed cycle still wins over the timeout
          if (bus.rd_vld) begin
            bus.rsp_vld  <= 1'b1;
            bus.rsp_addr <= cur_addr_reg;
            bus.rsp_data <= bus.data_r;
            state_reg    <= IDLE;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            bus.rsp_vld  <= 1'b1;
            bus.rsp_addr <= cur_addr_reg;
            bus.rsp_err  <= 1'b1;
            state_reg    <= IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pio_cmd_master.sv
// Scoreboard bench for pio_cmd_master: directed requests push expected
// commands/responses into queues; a negedge monitor pops and compares them.
module tb_pio_cmd_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pio_cmd_master_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  pio_cmd_master #(
    .ADDR_W(16), .DATA_W(32), .DEPTH(4), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t cmd_q[$];
  exp_t rsp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic void exp_cmd(input logic rw_i, input logic [15:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.rw = rw_i; e.addr = a; e.data = d; e.err = 1'b0; e.cyc = c;
    cmd_q.push_back(e);
  endfunction

  function automatic void exp_rsp(input logic rw_i, input logic [15:0] a, input logic [31:0] d,
                                  input logic err_i, input int c);
    exp_t e;
    e.rw = rw_i; e.addr = a; e.data = d; e.err = err_i; e.cyc = c;
    rsp_q.push_back(e);
  endfunction

  // Monitor: compares every command pulse and response pulse against the queues
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.cmd_vld === 1'b1) begin
      $display("cyc %0d cmd rw=%0d addr=%h data_w=%h", cyc, bus.rw, bus.addr, bus.data_w);
      chk("cmd_expected", 64'(cmd_q.size() != 0), 64'(1));
      if (cmd_q.size() != 0) begin
        e = cmd_q.pop_front();
        chk("cmd_rw", 64'(bus.rw), 64'(e.rw));
        chk("cmd_addr", 64'(bus.addr), 64'(e.addr));
        chk("cmd_data_w", 64'(bus.data_w), 64'(e.data));
        chk("cmd_drive_en", 64'(bus.drive_en), 64'(1));
        chk("cmd_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (rst === 1'b0) begin
      chk("bus_idle", 64'({bus.drive_en, bus.rw, bus.addr, bus.data_w}), 64'(0));
    end
    if (bus.rsp_vld === 1'b1) begin
      $display("cyc %0d rsp rw=%0d addr=%h data=%h err=%0d", cyc, bus.rsp_rw, bus.rsp_addr,
               bus.rsp_data, bus.rsp_err);
      chk("rsp_expected", 64'(rsp_q.size() != 0), 64'(1));
      if (rsp_q.size() != 0) begin
        e = rsp_q.pop_front();
        chk("rsp_rw", 64'(bus.rsp_rw), 64'(e.rw));
        chk("rsp_addr", 64'(bus.rsp_addr), 64'(e.addr));
        chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Present one request from a negedge; returns the cycle it was accepted in
  task automatic put_req(input logic rw_i, input logic [15:0] a, input logic [31:0] d, output int acc);
    int n = 0;
    bus.req_vld = 1'b1; bus.req_rw = rw_i; bus.req_addr = a; bus.req_data = d;
    while (!bus.req_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", 64'(bus.req_rdy), 64'(1));
    acc = cyc;
    @(negedge clk);
    bus.req_vld = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_data = '0;
  endtask

  // Drive a one-cycle rd_vld pulse during cycle 'target'
  task automatic pulse_rd(input int target, input logic [31:0] d);
    int n = 0;
    while (cyc < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rd_slot", 64'(cyc), 64'(target));
    bus.rd_vld = 1'b1; bus.data_r = d;
    @(negedge clk);
    bus.rd_vld = 1'b0; bus.data_r = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.idle && cmd_q.size() == 0 && rsp_q.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(cmd_q.size() + rsp_q.size()), 64'(0));
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c0;
    int a;
    rst = 1'b1;
    bus.req_vld = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_data = '0;
    bus.rd_vld = 1'b0; bus.data_r = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(bus.req_rdy), 64'(0));
    chk("rst_outputs", 64'({bus.cmd_vld, bus.rsp_vld, bus.rsp_err, bus.stray_rd}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rel_idle", 64'(bus.idle), 64'(1));
    chk("rel_rdy", 64'(bus.req_rdy), 64'(1));

    // Single write: cmd two cycles after accept, response one cycle later
    put_req(1'b1, 16'h0010, 32'hDEADBEEF, c0);
    exp_cmd(1'b1, 16'h0010, 32'hDEADBEEF, c0 + 2);
    exp_rsp(1'b1, 16'h0010, 32'h0, 1'b0, c0 + 3);
    wait_idle();

    // Read answered 3 cycles after the command
    put_req(1'b0, 16'h0020, 32'h0, c0);
    exp_cmd(1'b0, 16'h0020, 32'h0, c0 + 2);
    exp_rsp(1'b0, 16'h0020, 32'h12345678, 1'b0, c0 + 6);
    pulse_rd(c0 + 5, 32'h12345678);
    wait_idle();

    // Read answered in the command cycle itself
    put_req(1'b0, 16'h0024, 32'h0, c0);
    exp_cmd(1'b0, 16'h0024, 32'h0, c0 + 2);
    exp_rsp(1'b0, 16'h0024, 32'hCAFEF00D, 1'b0, c0 + 3);
    pulse_rd(c0 + 2, 32'hCAFEF00D);
    wait_idle();

    // Stall on a read, fill the FIFO with writes, then release
    put_req(1'b0, 16'h0030, 32'h0, c0);
    exp_cmd(1'b0, 16'h0030, 32'h0, c0 + 2);
    exp_rsp(1'b0, 16'h0030, 32'h0BADF00D, 1'b0, c0 + 9);
    for (int k = 0; k < 5; k++) begin
      exp_cmd(1'b1, 16'(16'h0100 + k), 32'(32'h1000_0000 + k), c0 + 10 + 2 * k);
      exp_rsp(1'b1, 16'(16'h0100 + k), 32'h0, 1'b0, c0 + 11 + 2 * k);
    end
    fork
      begin
        for (int k = 0; k < 4; k++) put_req(1'b1, 16'(16'h0100 + k), 32'(32'h1000_0000 + k), a);
        chk("full_rdy_low", 64'(bus.req_rdy), 64'(0));
        put_req(1'b1, 16'h0104, 32'h1000_0004, a);
        chk("fifth_accept_cyc", 64'(a), 64'(c0 + 10));
      end
      pulse_rd(c0 + 8, 32'h0BADF00D);
    join
    wait_idle();

    // Read timeout after 8 WAIT_RD cycles
    put_req(1'b0, 16'h0040, 32'h0, c0);
    exp_cmd(1'b0, 16'h0040, 32'h0, c0 + 2);
    exp_rsp(1'b0, 16'h0040, 32'h0, 1'b1, c0 + 11);
    wait_idle();

    // Data on the last WAIT_RD cycle beats the timeout
    put_req(1'b0, 16'h0044, 32'h0, c0);
    exp_cmd(1'b0, 16'h0044, 32'h0, c0 + 2);
    exp_rsp(1'b0, 16'h0044, 32'hA5A50001, 1'b0, c0 + 11);
    pulse_rd(c0 + 10, 32'hA5A50001);
    wait_idle();
    chk("stray_clear", 64'(bus.stray_rd), 64'(0));

    // Stray read data while idle
    pulse_rd(cyc + 1, 32'h00000077);
    chk("stray_set", 64'(bus.stray_rd), 64'(1));
    repeat (5) @(negedge clk);
    chk("stray_sticky", 64'(bus.stray_rd), 64'(1));

    // Reset while waiting on a read with two writes queued
    put_req(1'b0, 16'h0050, 32'h0, c0);
    exp_cmd(1'b0, 16'h0050, 32'h0, c0 + 2);
    put_req(1'b1, 16'h0060, 32'h00000011, a);
    put_req(1'b1, 16'h0064, 32'h00000022, a);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", 64'({bus.cmd_vld, bus.drive_en, bus.rw, bus.rsp_vld, bus.rsp_rw,
                               bus.rsp_err, bus.stray_rd, bus.req_rdy}), 64'(0));
    chk("midrst_buses", 64'({bus.addr, bus.rsp_addr}), 64'(0));
    chk("midrst_data", 64'({bus.data_w, bus.rsp_data}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rel_idle", 64'(bus.idle), 64'(1));
    chk("midrst_rel_rdy", 64'(bus.req_rdy), 64'(1));
    repeat (20) @(negedge clk);
    chk("midrst_quiet", 64'(cmd_q.size() + rsp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
